// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: owns paddle/ball positions, scores and the serve/point/over flow.
// All state advances only on frame_tick, so outputs hold steady for a whole frame.
module pong_game_ctrl #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BORDER       = 10,
  parameter int unsigned PADDLE_LEN   = 50,
  parameter int unsigned PADDLE_THK   = 10,
  parameter int unsigned PADDLE_X_OFS = 40,
  parameter int unsigned BALL_SIDE    = 10,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned POINT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        serve,
  output logic [11:0] paddle1,
  output logic [11:0] paddle2,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic        flag,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over
);

  typedef logic [11:0] coord_t;
  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPoint, StOver} state_e;

  localparam coord_t PadMin    = coord_t'(BORDER);
  localparam coord_t PadMax    = coord_t'(V_ACTIVE - BORDER - PADDLE_LEN);
  localparam coord_t PadInit   = coord_t'((V_ACTIVE - PADDLE_LEN) / 2);
  localparam coord_t PadLen    = coord_t'(PADDLE_LEN);
  localparam coord_t PadStep   = coord_t'(PADDLE_SPEED);
  localparam coord_t Side      = coord_t'(BALL_SIDE);
  localparam coord_t Step      = coord_t'(BALL_SPEED);
  localparam coord_t BallX0    = coord_t'((H_ACTIVE - BALL_SIDE) / 2);
  localparam coord_t BallY0    = coord_t'((V_ACTIVE - BALL_SIDE) / 2);
  localparam coord_t BallYMin  = coord_t'(BORDER);
  localparam coord_t BallYMax  = coord_t'(V_ACTIVE - BORDER - BALL_SIDE);
  localparam coord_t LeftFace  = coord_t'(PADDLE_X_OFS + PADDLE_THK);
  localparam coord_t RightFace = coord_t'(H_ACTIVE - PADDLE_X_OFS - PADDLE_THK - 1);
  localparam coord_t LeftGoal  = coord_t'(BORDER);
  localparam coord_t RightGoal = coord_t'(H_ACTIVE - BORDER);
  localparam int unsigned CntW = $clog2(POINT_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(POINT_FRAMES - 1);
  localparam logic [3:0] WinScore = 4'(WIN_SCORE);

  state_e          state_q, state_d;
  coord_t          paddle1_q, paddle1_d, paddle2_q, paddle2_d;
  coord_t          ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic            dx_q, dx_d, dy_q, dy_d;  // 1 = moving toward larger coordinate
  logic [3:0]      score1_q, score1_d, score2_q, score2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d, game_over_q, game_over_d;
  logic            rows1, rows2;

  function automatic coord_t move_paddle(input coord_t pos, input logic up, input logic dn);
    coord_t res;
    res = pos;
    if (up && !dn) begin
      res = (pos <= PadMin + PadStep) ? PadMin : pos - PadStep;
    end else if (dn && !up) begin
      res = (pos + PadStep >= PadMax) ? PadMax : pos + PadStep;
    end
    return res;
  endfunction

  assign rows1 = (ball_y_q + Side > paddle1_q) && (ball_y_q < paddle1_q + PadLen);
  assign rows2 = (ball_y_q + Side > paddle2_q) && (ball_y_q < paddle2_q + PadLen);

  always_comb begin
    state_d   = state_q;
    paddle1_d = paddle1_q;
    paddle2_d = paddle2_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    cnt_d     = cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (serve) begin
            state_d  = StServe;
            ball_x_d = BallX0;
            ball_y_d = BallY0;
          end
        end
        StServe: begin
          paddle1_d = move_paddle(paddle1_q, p1_up, p1_dn);
          paddle2_d = move_paddle(paddle2_q, p2_up, p2_dn);
          ball_x_d  = BallX0;
          ball_y_d  = BallY0;
          if (serve) state_d = StPlay;
        end
        StPlay: begin
          paddle1_d = move_paddle(paddle1_q, p1_up, p1_dn);
          paddle2_d = move_paddle(paddle2_q, p2_up, p2_dn);
          if (!dy_q && ball_y_q <= BallYMin + Step) begin
            ball_y_d = BallYMin;
            dy_d     = 1'b1;
          end else if (dy_q && ball_y_q + Step >= BallYMax) begin
            ball_y_d = BallYMax;
            dy_d     = 1'b0;
          end else begin
            ball_y_d = dy_q ? ball_y_q + Step : ball_y_q - Step;
          end
          // dx is left untouched on a miss, so it already points at the conceding player.
          if (!dx_q && ball_x_q >= LeftFace && ball_x_q <= LeftFace + Step && rows1) begin
            ball_x_d = LeftFace;
            dx_d     = 1'b1;
          end else if (dx_q && ball_x_q + Side <= RightFace &&
                       ball_x_q + Side + Step >= RightFace && rows2) begin
            ball_x_d = RightFace - Side;
            dx_d     = 1'b0;
          end else if (!dx_q && ball_x_q <= LeftGoal + Step) begin
            score2_d = score2_q + {3'b000, score2_q != 4'hF};
            state_d  = StPoint;
            cnt_d    = '0;
          end else if (dx_q && ball_x_q + Side + Step >= RightGoal) begin
            score1_d = score1_q + {3'b000, score1_q != 4'hF};
            state_d  = StPoint;
            cnt_d    = '0;
          end else begin
            ball_x_d = dx_q ? ball_x_q + Step : ball_x_q - Step;
          end
        end
        StPoint: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (score1_q == WinScore || score2_q == WinScore) begin
              state_d = StOver;
            end else begin
              state_d  = StServe;
              ball_x_d = BallX0;
              ball_y_d = BallY0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOver: begin
          if (serve) begin
            state_d  = StServe;
            score1_d = '0;
            score2_d = '0;
            ball_x_d = BallX0;
            ball_y_d = BallY0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    flag_d      = (state_d != StIdle);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      paddle1_q   <= PadInit;
      paddle2_q   <= PadInit;
      ball_x_q    <= BallX0;
      ball_y_q    <= BallY0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddle1_q   <= paddle1_d;
      paddle2_q   <= paddle2_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      game_over_q <= game_over_d;
    end
  end

  assign paddle1   = paddle1_q;
  assign paddle2   = paddle2_q;
  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign flag      = flag_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a hand table, reset/clamp sequences, then long randomized play
// compared frame by frame against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int MIdle = 0, MServe = 1, MPlay = 2, MPoint = 3, MOver = 4;

  logic        clk, rst, frame_tick, p1_up, p1_dn, p2_up, p2_dn, serve;
  logic [11:0] paddle1, paddle2, ball_x, ball_y;
  logic        flag, game_over;
  logic [3:0]  score1, score2;

  int n_vec, n_bad;
  int m_mode, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_frozen;
  bit saw_over, saw_restart;

  typedef struct {
    bit sv, u1, d1, u2, d2;
    int eflag, ep1, ep2, ebx, eby;
  } vec_t;
  vec_t tbl[9];

  pong_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .p1_up     (p1_up),
    .p1_dn     (p1_dn),
    .p2_up     (p2_up),
    .p2_dn     (p2_dn),
    .serve     (serve),
    .paddle1   (paddle1),
    .paddle2   (paddle2),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .flag      (flag),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".paddle1"}, int'(paddle1), m_p1);
    check({tag, ".paddle2"}, int'(paddle2), m_p2);
    check({tag, ".ball_x"}, int'(ball_x), m_bx);
    check({tag, ".ball_y"}, int'(ball_y), m_by);
    check({tag, ".score1"}, int'(score1), m_s1);
    check({tag, ".score2"}, int'(score2), m_s2);
    check({tag, ".flag"}, int'(flag), (m_mode != MIdle) ? 1 : 0);
    check({tag, ".game_over"}, int'(game_over), (m_mode == MOver) ? 1 : 0);
  endtask

  function automatic int pad_move(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 10) ? 10 : p - 4;
    if (dn && !up) return (p + 4 > 420) ? 420 : p + 4;
    return p;
  endfunction

  task automatic centre_ball();
    m_bx = 315;
    m_by = 235;
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_p1 = 215; m_p2 = 215; centre_ball();
    m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_frozen = 0;
  endtask

  task automatic model_step(input bit sv, input bit u1, input bit d1, input bit u2,
                            input bit d2);
    int op1, op2, ny, ndy;
    op1 = m_p1;
    op2 = m_p2;
    case (m_mode)
      MIdle: if (sv) begin m_mode = MServe; centre_ball(); end
      MServe: begin
        m_p1 = pad_move(m_p1, u1, d1);
        m_p2 = pad_move(m_p2, u2, d2);
        centre_ball();
        if (sv) m_mode = MPlay;
      end
      MPlay: begin
        m_p1 = pad_move(m_p1, u1, d1);
        m_p2 = pad_move(m_p2, u2, d2);
        ndy = m_dy;
        if (m_dy < 0 && m_by - 2 <= 10) begin ny = 10; ndy = 1; end
        else if (m_dy > 0 && m_by + 2 >= 460) begin ny = 460; ndy = -1; end
        else ny = m_by + m_dy * 2;
        if (m_dx < 0 && m_bx >= 50 && m_bx - 2 <= 50 && m_by + 10 > op1 && m_by < op1 + 50)
        begin
          m_bx = 50; m_dx = 1;
        end else if (m_dx > 0 && m_bx + 10 <= 589 && m_bx + 12 >= 589 &&
                     m_by + 10 > op2 && m_by < op2 + 50) begin
          m_bx = 579; m_dx = -1;
        end else if (m_bx - 2 <= 10) begin
          m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
          m_mode = MPoint; m_frozen = 0; m_dx = -1;
        end else if (m_bx + 12 >= 630) begin
          m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
          m_mode = MPoint; m_frozen = 0; m_dx = 1;
        end else begin
          m_bx = m_bx + m_dx * 2;
        end
        m_by = ny;
        m_dy = ndy;
      end
      MPoint: begin
        m_frozen++;
        if (m_frozen == 60) begin
          if (m_s1 == 7 || m_s2 == 7) begin
            m_mode = MOver;
            saw_over = 1'b1;
          end else begin
            m_mode = MServe;
            centre_ball();
          end
        end
      end
      MOver: if (sv) begin
        m_s1 = 0; m_s2 = 0; m_mode = MServe; centre_ball();
        saw_restart = 1'b1;
      end
      default: m_mode = MIdle;
    endcase
  endtask

  task automatic scramble();
    {serve, p1_up, p1_dn, p2_up, p2_dn} = 5'($urandom);
  endtask

  // One frame: tick with the given buttons, then 'gap' idle cycles of junk inputs.
  task automatic tick(input bit sv, input bit u1, input bit d1, input bit u2, input bit d2,
                      input int gap);
    @(negedge clk);
    serve = sv; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    scramble();
    model_step(sv, u1, d1, u2, d2);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      scramble();
    end
  endtask

  function automatic bit [1:0] ai(input int pad, input int by, input bit good);
    int c, b, r;
    c = pad + 25;
    b = by + 5;
    if (good) begin
      if (c > b + 2) return 2'b10;
      if (c < b - 2) return 2'b01;
      return 2'b00;
    end
    r = $urandom_range(0, 15);
    if (r == 0) return 2'b10;
    if (r == 1) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    bit [1:0] b1, b2;
    bit good1, good2, sv;
    int t;
    n_vec = 0; n_bad = 0; saw_over = 0; saw_restart = 0;
    tbl[0] = '{0, 1, 0, 0, 0, 0, 215, 215, 315, 235};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 215, 215, 315, 235};
    tbl[2] = '{0, 1, 0, 0, 0, 1, 211, 215, 315, 235};
    tbl[3] = '{0, 1, 1, 0, 0, 1, 211, 215, 315, 235};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 211, 219, 315, 235};
    tbl[5] = '{0, 0, 1, 1, 0, 1, 215, 215, 315, 235};
    tbl[6] = '{1, 1, 0, 0, 0, 1, 211, 215, 315, 235};
    tbl[7] = '{1, 0, 0, 0, 0, 1, 211, 215, 317, 237};
    tbl[8] = '{0, 0, 0, 0, 0, 1, 211, 215, 319, 239};

    rst = 1'b1; frame_tick = 1'b0;
    serve = 0; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("reset");

    // Table: idle, serve, paddle moves in SERVE, held serve advancing one state per tick.
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].sv, tbl[i].u1, tbl[i].d1, tbl[i].u2, tbl[i].d2, 0);
      check($sformatf("tbl%0d.flag", i), int'(flag), tbl[i].eflag);
      check($sformatf("tbl%0d.paddle1", i), int'(paddle1), tbl[i].ep1);
      check($sformatf("tbl%0d.paddle2", i), int'(paddle2), tbl[i].ep2);
      check($sformatf("tbl%0d.ball_x", i), int'(ball_x), tbl[i].ebx);
      check($sformatf("tbl%0d.ball_y", i), int'(ball_y), tbl[i].eby);
    end

    // Asynchronous reset mid-PLAY, between clock edges and without a tick.
    repeat (5) begin
      tick(0, 0, 1, 1, 0, 1);
      check_model("play");
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst.flag", int'(flag), 0);
    check("async_rst.paddle1", int'(paddle1), 215);
    check("async_rst.paddle2", int'(paddle2), 215);
    check("async_rst.ball_x", int'(ball_x), 315);
    check("async_rst.ball_y", int'(ball_y), 235);
    check("async_rst.score1", int'(score1), 0);
    check("async_rst.game_over", int'(game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Paddle clamps in SERVE.
    tick(1, 0, 0, 0, 0, 0);
    check_model("serve");
    for (int i = 0; i < 60; i++) begin
      tick(0, 1, 0, 0, 0, 0);
      check_model("p1_up");
    end
    check("clamp_top", int'(paddle1), 10);
    tick(0, 1, 1, 0, 0, 0);
    check("up_dn_hold", int'(paddle1), 10);
    for (int i = 0; i < 110; i++) begin
      tick(0, 0, 1, 0, 0, 0);
      check_model("p1_dn");
    end
    check("clamp_bot", int'(paddle1), 420);

    // Randomized play until a full game has ended and been restarted.
    good1 = 1; good2 = 0; t = 0;
    while (t < 12000 && !(saw_restart && t >= 2000)) begin
      if (t % 400 == 0) begin
        good1 = bit'($urandom_range(0, 1));
        good2 = bit'($urandom_range(0, 1));
      end
      b1 = ai(m_p1, m_by, good1);
      b2 = ai(m_p2, m_by, good2);
      if ($urandom_range(0, 15) == 0) begin
        b1 = 2'($urandom);
        b2 = 2'($urandom);
      end
      sv = ($urandom_range(0, 3) == 0);
      tick(sv, b1[1], b1[0], b2[1], b2[0], $urandom_range(0, 1));
      check_model("rand");
      t++;
    end
    if (!saw_restart) begin
      n_vec++;
      n_bad++;
      $display("FAIL game_restart: got no restart after %0d frames, expected one", t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
